// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  // All segments off (active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segment patterns, bit6 = g ... bit0 = a. Entry n sits at [n].
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low seven-segment pattern; unknown nibbles give all-off.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // An X/Z nibble never compares true, so the all-off default survives.
  always_comb begin
    seg_o = SEG_OFF;
    for (int unsigned i = 0; i < 16; i++) begin
      if (nibble_i == 4'(i)) seg_o = SEG_TABLE[i[3:0]];
    end
  end

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed 4-digit common-anode driver with per-slot blanking and
// once-per-frame shadow capture of the display inputs.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] display,
  input  logic [3:0]  points,
  input  logic [3:0]  enable_digits,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam digit_idx_t       IDX_FIRST = digit_idx_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [15:0]      shadow_display_q, shadow_display_d;
  logic [3:0]       shadow_points_q, shadow_points_d;
  logic [3:0]       shadow_en_q, shadow_en_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_start_q, frame_start_d;

  logic             load;
  logic             active;
  logic [3:0]       cur_nibble;
  logic [6:0]       cur_seg;

  assign cur_nibble = shadow_display_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  // Next-state for slot counter, digit index, shadow capture and output registers.
  always_comb begin
    load             = (cnt_q == '0) && (idx_q == IDX_FIRST);
    cnt_d            = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d            = (cnt_q == CNT_MAX) ? idx_q - 1'b1 : idx_q;
    shadow_display_d = shadow_display_q;
    shadow_points_d  = shadow_points_q;
    shadow_en_d      = shadow_en_q;
    if (load) begin
      shadow_display_d = display;
      shadow_points_d  = points;
      shadow_en_d      = enable_digits;
    end

    // Outputs are built from pre-edge state only; disabled digits never touch
    // the decoded nibble, so undriven inputs cannot leak to the pins.
    active        = (cnt_q >= CNT_BLANK) && (shadow_en_q[idx_q] == 1'b1);
    an_d          = '1;
    seg_d         = SEG_OFF;
    dp_d          = 1'b1;
    if (active) begin
      an_d[idx_q] = 1'b0;
      seg_d       = cur_seg;
      dp_d        = shadow_points_q[idx_q];
    end
    frame_start_d = load;
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q            <= '0;
      idx_q            <= IDX_FIRST;
      shadow_display_q <= '0;
      shadow_points_q  <= '1;
      shadow_en_q      <= '0;
      an_q             <= '1;
      seg_q            <= SEG_OFF;
      dp_q             <= 1'b1;
      frame_start_q    <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      shadow_display_q <= shadow_display_d;
      shadow_points_q  <= shadow_points_d;
      shadow_en_q      <= shadow_en_d;
      an_q             <= an_d;
      seg_q            <= seg_d;
      dp_q             <= dp_d;
      frame_start_q    <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller with CLK_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] display = '0;
  logic [3:0]  points = '1;
  logic [3:0]  enable_digits = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  seg7_scan_controller #(
    .CLK_DIV      (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .display       (display),
    .points        (points),
    .enable_digits (enable_digits),
    .seg           (seg),
    .dp            (dp),
    .an            (an),
    .frame_start   (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state: edges since reset release and the frame snapshot.
  logic        model_on = 1'b0;
  int unsigned k = 0;
  logic [15:0] m_disp;
  logic [3:0]  m_pts;
  logic [3:0]  m_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] ref_dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  4'hF: return 7'b0001110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Model: position p in the 32-cycle frame; outputs after edge p reflect p.
  always @(posedge clk) begin
    if (model_on) begin
      int unsigned p, slot, c, d;
      exp_t e;
      p    = k % 32;
      slot = p / 8;
      c    = p % 8;
      d    = 3 - slot;
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
      e.dp  = 1'b1;
      e.fs  = (p == 0);
      if (c >= 2 && m_en[d]) begin
        e.an    = 4'b1111;
        e.an[d] = 1'b0;
        e.seg   = ref_dec(m_disp[d*4 +: 4]);
        e.dp    = m_pts[d];
      end
      if (p == 0) begin
        m_disp = display;
        m_pts  = points;
        m_en   = enable_digits;
      end
      exp_q.push_back(e);
      k++;
    end
  end

  // Compare each predicted output on the following falling edge.
  always @(negedge clk) begin
    if (model_on && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("an", 32'(an), 32'(e.an));
      check("seg", 32'(seg), 32'(e.seg));
      check("dp", 32'(dp), 32'(e.dp));
      check("frame_start", 32'(frame_start), 32'(e.fs));
      check("no_x", 32'($isunknown({an, seg, dp, frame_start})), 32'(0));
    end
  end

  task automatic check_blank(input string tag);
    check({tag, "_an"}, 32'(an), 32'h0000000F);
    check({tag, "_seg"}, 32'(seg), 32'h0000007F);
    check({tag, "_dp"}, 32'(dp), 32'(1));
    check({tag, "_fs"}, 32'(frame_start), 32'(0));
  endtask

  // Wait (bounded) for the negedge at which k%32 equals pos.
  task automatic wait_pos(input int unsigned pos);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while ((k % 32) != pos && n < 80) begin
      @(negedge clk);
      n++;
    end
    if ((k % 32) != pos) check("wait_pos_timeout", 32'(k % 32), 32'(pos));
  endtask

  task automatic release_reset();
    @(negedge clk);
    k        = 0;
    model_on = 1'b1;
    rst_n    = 1'b1;
  endtask

  initial begin
    // 1: reset with random inputs
    display       = 16'($urandom);
    points        = 4'($urandom);
    enable_digits = 4'($urandom);
    repeat (3) begin
      @(negedge clk);
      check_blank("reset");
    end

    // 2: basic pattern
    display       = 16'h0128;
    points        = 4'hF;
    enable_digits = 4'hF;
    release_reset();
    repeat (64) @(negedge clk);

    // 3: upper digits only, lower nibbles undriven
    wait_pos(0);
    display       = 16'h01zz;
    enable_digits = 4'b1100;
    repeat (128) @(negedge clk);

    // 4: mid-frame change must wait for the next load
    display       = 16'h0128;
    enable_digits = 4'hF;
    wait_pos(12);
    display = 16'h3333;
    repeat (64) @(negedge clk);

    // Full decode sweep, one frame per group of four nibbles
    wait_pos(4);
    display = 16'h0123;
    wait_pos(4);
    display = 16'h4567;
    wait_pos(4);
    display = 16'h89AB;
    wait_pos(4);
    display = 16'hCDEF;
    repeat (64) @(negedge clk);

    // 5: decimal point on digit 0 only
    points = 4'b1110;
    repeat (64) @(negedge clk);

    // 6: asynchronous reset mid digit-1 slot
    wait_pos(20);
    check("pre_reset_an", 32'(an), 32'h0000000D);
    #2;
    rst_n    = 1'b0;
    model_on = 1'b0;
    exp_q.delete();
    #1;
    check_blank("async_reset");
    repeat (2) @(negedge clk);
    check_blank("held_reset");
    display = 16'hA5C0;
    points  = 4'b0111;
    release_reset();
    repeat (64) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
